div_unit: RTL

- Iterative 32-bit integer divider serving the DIV and DIVU instructions of the multicycle CPU.
- Sits directly downstream of the controller: it takes div_start/divu_start pulses plus Rs/Rt operands and returns quotient/remainder for the HI/LO write path.
- While it works it raises busy, which the controller uses to stall.
- Algorithm: restoring division on magnitudes, one quotient bit per cycle, then a sign-fix cycle.

---
 rtl/div_unit_pkg.sv | 14 +
 rtl/div_unit_step.sv | 29 ++
 rtl/div_unit.sv | 94 +++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider: datapath width and the
// one-hot state encoding shared with the controller.
package div_unit_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_RUN  = 4'b0010,
    S_FIX  = 4'b0100,
    S_DONE = 4'b1000
  } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the
// divisor magnitude, keep the difference and set the quotient LSB if non-negative.
module div_step
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dsor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           ge;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    trial   = shifted - {1'b0, dsor};
    // A set top bit on the shifted value already exceeds any divisor; otherwise
    // the top bit of the trial difference is the borrow.
    ge      = shifted[WIDTH] | ~trial[WIDTH];
    rem_out = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_unit.sv
// Iterative DIV/DIVU unit: 32 restoring iterations on magnitudes followed by
// one sign-fix cycle; busy stalls the controller, done pulses with the result.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_r, quo_r, dsor_r;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic             neg_q, neg_r;
  logic             accept;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in (rem_r),
    .quo_in (quo_r),
    .dsor   (dsor_r),
    .rem_out(rem_step),
    .quo_out(quo_step)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        accept     = start;
        state_next = start ? S_RUN : S_IDLE;
      end
      S_RUN:   if (cnt == '1) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_RUN) || (state_next == S_FIX);
      done  <= (state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      rem_r     <= '0;
      quo_r     <= '0;
      dsor_r    <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt    <= '0;
      rem_r  <= '0;
      quo_r  <= mag(dividend, is_signed);
      dsor_r <= mag(divisor, is_signed);
      neg_q  <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      neg_r  <= is_signed & dividend[WIDTH-1];
    end else if (state == S_RUN) begin
      rem_r <= rem_step;
      quo_r <= quo_step;
      cnt   <= cnt + 1'b1;
    end else if (state == S_FIX) begin
      // Divide-by-zero keeps the all-ones quotient regardless of signs.
      quotient  <= (neg_q && dsor_r != '0) ? (~quo_r + 1'b1) : quo_r;
      remainder <= neg_r ? (~rem_r + 1'b1) : rem_r;
    end
  end

endmodule
